prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a byte stream (word count, then big-endian 32-bit
// words), assembles the words into a flat RAM image for the CPU, and holds
// the CPU in reset until the image is complete and valid.
module prog_loader #(
  parameter int RAM_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [RAM_SIZE*32-1:0] ram,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            words_loaded
);

  typedef enum logic [2:0] {IDLE, COUNT, LOAD, DONE, ERROR} state_t;

  localparam logic [7:0] ram_max = 8'(RAM_SIZE);

  state_t      state_reg;
  logic [1:0]  byte_cnt_reg;
  logic [7:0]  n_words_reg;
  logic [23:0] asm_reg;         // first three bytes of the word in flight
  logic [31:0] ram_reg [RAM_SIZE];

  logic        xfer;
  logic        clear_img;
  logic        word_wr;
  logic [31:0] word_data;

  // A byte moves only when both sides agree; a new load wipes the image.
  always_comb begin
    xfer      = in_valid & in_ready;
    clear_img = load_start &&
                (state_reg == IDLE || state_reg == DONE || state_reg == ERROR);
    word_wr   = xfer && (state_reg == LOAD) && (byte_cnt_reg == 2'd3);
    word_data = {asm_reg, in_data};
  end

  // Load sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 8'd0;
      byte_cnt_reg <= 2'd0;
      n_words_reg  <= 8'd0;
      asm_reg      <= 24'd0;
    end else begin
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (load_start) begin
            state_reg    <= COUNT;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 8'd0;
            byte_cnt_reg <= 2'd0;
            asm_reg      <= 24'd0;
          end
        end
        COUNT: begin
          if (xfer) begin
            if (in_data == 8'd0 || in_data > ram_max) begin
              state_reg <= ERROR;
              error     <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              n_words_reg <= in_data;
              state_reg   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            case (byte_cnt_reg)
              2'd0: asm_reg[23:16] <= in_data;
              2'd1: asm_reg[15:8]  <= in_data;
              2'd2: asm_reg[7:0]   <= in_data;
              default: begin
                words_loaded <= words_loaded + 8'd1;
                if (words_loaded + 8'd1 == n_words_reg) begin
                  state_reg <= DONE;
                  done      <= 1'b1;
                  cpu_hold  <= 1'b0;
                  in_ready  <= 1'b0;
                end
              end
            endcase
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Image storage: cleared on reset or a new load, one word written per 4th byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RAM_SIZE; i++) begin
      if (!reset || clear_img)
        ram_reg[i] <= '0;
      else if (word_wr && words_loaded == 8'(i))
        ram_reg[i] <= word_data;
    end
  end

  // Flatten the word array onto the CPU-facing bus, word i at bits (i+1)*32-1 : i*32.
  for (genvar gi = 0; gi < RAM_SIZE; gi++) begin : g_pack
    assign ram[gi*32 +: 32] = ram_reg[gi];
  end

endmodule
